// File: rtl/neuron_step_scheduler.sv
// neuron_step_scheduler
// Time-multiplexes one pipelined neuron core across N_NEURONS neurons.
// Owns the per-neuron v/w state memory. Each step issues one neuron per
// cycle to the core and tracks in-flight neurons with a tag pipeline. It
// writes the core results back to memory and reports threshold-crossing
// spikes.
//
// Build option: define NEURON_SPIKE_RESET_EN to make a spiking writeback
// store v = V_INIT and w = core_w_out + W_JUMP instead of the raw core
// outputs. Spike reporting is the same in both builds.
module neuron_step_scheduler #(
  parameter int             N_NEURONS = 16,
  parameter int             ADDR_W    = 4,
  parameter int             W         = 16,
  parameter int             CORE_LAT  = 4,
  parameter logic [W-1:0]   V_INIT    = 16'hECE1,
  parameter logic [W-1:0]   W_INIT    = 16'hF600,
  parameter logic [W-1:0]   SPIKE_TH  = 16'h1000,
  parameter logic [W-1:0]   W_JUMP    = 16'h0200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] i_addr,
  input  logic [W-1:0]      i_data,
  output logic [W-1:0]      core_i,
  output logic [W-1:0]      core_v,
  output logic [W-1:0]      core_w,
  input  logic [W-1:0]      core_v_out,
  input  logic [W-1:0]      core_w_out,
  output logic              spike_valid,
  output logic [ADDR_W-1:0] spike_id,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [W-1:0]      rd_v,
  output logic [W-1:0]      rd_w
);

`ifdef NEURON_SPIKE_RESET_EN
  localparam bit SPIKE_RESET_EN = 1'b1;
`else
  localparam bit SPIKE_RESET_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // One in-flight neuron: which memory slot it returns to and the membrane
  // value it had when issued (needed for the rising-crossing spike test).
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [W-1:0]      old_v;
  } tag_t;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_idx;
  tag_t                r_tag [0:CORE_LAT];
  logic [W-1:0]        r_mem_v [N_NEURONS];
  logic [W-1:0]        r_mem_w [N_NEURONS];

  logic                r_busy;
  logic                r_done;
  logic                r_spike_valid;
  logic [ADDR_W-1:0]   r_spike_id;
  logic [W-1:0]        r_core_i;
  logic [W-1:0]        r_core_v;
  logic [W-1:0]        r_core_w;
  logic [W-1:0]        r_rd_v;
  logic [W-1:0]        r_rd_w;

  // ------------------------------------------------------------------
  // Decode
  // ------------------------------------------------------------------
  logic                w_issue;
  logic                w_last_issue;
  logic                w_wb;
  logic                w_pending;
  logic                w_final_wb;
  logic                w_spike;
  tag_t                w_wb_tag;
  logic [W-1:0]        w_wb_v;
  logic [W-1:0]        w_wb_w;
  logic [W-1:0]        w_issue_v;
  logic [W-1:0]        w_issue_w;

  assign w_issue      = (r_state == ST_ISSUE);
  assign w_last_issue = w_issue && (r_idx == LAST_IDX);
  assign w_issue_v    = r_mem_v[r_idx];
  assign w_issue_w    = r_mem_w[r_idx];
  assign w_wb_tag     = r_tag[CORE_LAT];
  assign w_wb         = w_wb_tag.valid;

  // Any neuron still in flight behind the one at the writeback stage.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_pending = 1'b0;
    for (int t = 0; t < CORE_LAT; t++) begin
      w_pending = w_pending | r_tag[t].valid;
    end
  end

  // The step ends on the edge that retires the last in-flight neuron.
  assign w_final_wb = (r_state == ST_DRAIN) && w_wb && !w_pending;

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (start)        w_next_state = ST_ISSUE;
      ST_ISSUE: if (w_last_issue) w_next_state = ST_DRAIN;
      ST_DRAIN: if (w_final_wb)   w_next_state = ST_IDLE;
      default:                    w_next_state = ST_IDLE;
    endcase
  end

  // Status flags: busy mirrors "not heading to IDLE", done marks the final writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next_state != ST_IDLE);
      r_done <= w_final_wb;
    end
  end

  // ------------------------------------------------------------------
  // Issue side
  // ------------------------------------------------------------------
  // Issue index walks 0..N_NEURONS-1 once per step and parks at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_issue) begin
      r_idx <= w_last_issue ? '0 : r_idx + ADDR_W'(1);
    end
  end

  // The current buffer is addressed directly by the issue index.
  assign i_addr = w_issue ? r_idx : '0;

  // Core input registers load on issue edges and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_core_i <= '0;
      r_core_v <= '0;
      r_core_w <= '0;
    end else if (w_issue) begin
      r_core_i <= i_data;
      r_core_v <= w_issue_v;
      r_core_w <= w_issue_w;
    end
  end

  // Tag pipeline: one stage per cycle of core latency plus the input register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t <= CORE_LAT; t++) begin
        r_tag[t] <= '0;
      end
    end else begin
      r_tag[0] <= w_issue ? '{valid: 1'b1, addr: r_idx, old_v: w_issue_v} : '0;
      for (int t = 1; t <= CORE_LAT; t++) begin
        r_tag[t] <= r_tag[t-1];
      end
    end
  end

  // ------------------------------------------------------------------
  // Writeback side
  // ------------------------------------------------------------------
  // Spike = rising crossing of the threshold (signed); optional post-spike reset.
  always_comb begin
    w_spike = ($signed(core_v_out) >= $signed(SPIKE_TH)) &&
              ($signed(w_wb_tag.old_v) < $signed(SPIKE_TH));
    w_wb_v  = core_v_out;
    w_wb_w  = core_w_out;
    if (SPIKE_RESET_EN && w_spike) begin
      w_wb_v = V_INIT;
      w_wb_w = core_w_out + W_JUMP;
    end
  end

  // State memory: reset to the resting point, written by the retiring tag.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the state memory is reset on purpose; every neuron must restart at V_INIT/W_INIT, so it is built from flops rather than a RAM macro.
    if (rst) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        r_mem_v[n] <= V_INIT;
        r_mem_w[n] <= W_INIT;
      end
    end else if (w_wb) begin
      r_mem_v[w_wb_tag.addr] <= w_wb_v;
      r_mem_w[w_wb_tag.addr] <= w_wb_w;
    end
  end

  // Spike report: pulse on the writeback edge, id holds its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spike_valid <= 1'b0;
      r_spike_id    <= '0;
    end else begin
      r_spike_valid <= w_wb && w_spike;
      if (w_wb && w_spike) begin
        r_spike_id <= w_wb_tag.addr;
      end
    end
  end

  // Host readback: one-cycle registered read, usable at any time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_v <= V_INIT;
      r_rd_w <= W_INIT;
    end else begin
      r_rd_v <= r_mem_v[rd_addr];
      r_rd_w <= r_mem_w[rd_addr];
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign busy        = r_busy;
  assign done        = r_done;
  assign core_i      = r_core_i;
  assign core_v      = r_core_v;
  assign core_w      = r_core_w;
  assign spike_valid = r_spike_valid;
  assign spike_id    = r_spike_id;
  assign rd_v        = r_rd_v;
  assign rd_w        = r_rd_w;

endmodule

// File: tb/tb_neuron_step_scheduler.sv
// tb_neuron_step_scheduler
// Drives neuron_step_scheduler with a stub core (v_out = v + i, w_out = w,
// four-cycle latency). A step-level model predicts, per clock edge, which
// neuron is being issued and which one retires, and every output is compared
// on the falling edge. Hand-computed literals pin the model down.
module tb_neuron_step_scheduler;

  localparam int          N   = 16;
  localparam int          L   = 4;
  localparam logic [15:0] VI  = 16'hECE1;
  localparam logic [15:0] WI  = 16'hF600;
  localparam logic [15:0] TH  = 16'h1000;
  localparam logic [15:0] WJ  = 16'h0200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, spike_valid;
  logic [3:0]  i_addr, spike_id;
  logic [3:0]  rd_addr = 4'd0;
  logic [15:0] i_data, core_i, core_v, core_w, core_v_out, core_w_out, rd_v, rd_w;
  logic [15:0] cur [N];

  always #5 clk = ~clk;

  neuron_step_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .i_addr(i_addr), .i_data(i_data),
    .core_i(core_i), .core_v(core_v), .core_w(core_w),
    .core_v_out(core_v_out), .core_w_out(core_w_out),
    .spike_valid(spike_valid), .spike_id(spike_id),
    .rd_addr(rd_addr), .rd_v(rd_v), .rd_w(rd_w)
  );

  assign i_data = cur[i_addr];

  // Stub core: samples its inputs each edge and presents the result L cycles later.
  logic [15:0] pv [L];
  logic [15:0] pw [L];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < L; s++) begin
        pv[s] <= '0;
        pw[s] <= '0;
      end
    end else begin
      pv[0] <= core_v + core_i;
      pw[0] <= core_w;
      for (int s = 1; s < L; s++) begin
        pv[s] <= pv[s-1];
        pw[s] <= pw[s-1];
      end
    end
  end
  assign core_v_out = pv[L-1];
  assign core_w_out = pw[L-1];

  // ------------------------------------------------------------------
  // Scoreboard
  // ------------------------------------------------------------------
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
  endtask

  // ------------------------------------------------------------------
  // Step model: neuron k is issued on edge S+k+1, retires on edge S+k+L+2,
  // and the step is done on edge S+N+L+1.
  // ------------------------------------------------------------------
  logic [15:0] m_v [N];
  logic [15:0] m_w [N];
  bit          m_active = 1'b0;
  int          m_c = 0;
  int          edge_n = 0;
  int          s_edge = 0;
  int          steps_started = 0;
  logic        e_busy = 1'b0, e_done = 1'b0, e_spike = 1'b0;
  logic [3:0]  e_id = '0;
  logic [15:0] e_core_i = '0, e_core_v = '0, e_core_w = '0;
  logic [15:0] e_rd_v = VI, e_rd_w = WI;

  task automatic retire(input int k);
    logic [15:0] nv, nw;
    bit          sp;
    nv = m_v[k] + cur[k];
    nw = m_w[k];
    sp = ($signed(nv) >= $signed(TH)) && ($signed(m_v[k]) < $signed(TH));
    if (sp) begin
      e_spike = 1'b1;
      e_id    = 4'(k);
`ifdef NEURON_SPIKE_RESET_EN
      nv = VI;
      nw = nw + WJ;
`endif
    end
    m_v[k] = nv;
    m_w[k] = nw;
  endtask

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      m_active = 1'b0; m_c = 0;
      e_busy = 1'b0; e_done = 1'b0; e_spike = 1'b0; e_id = '0;
      e_core_i = '0; e_core_v = '0; e_core_w = '0;
      e_rd_v = VI; e_rd_w = WI;
      for (int k = 0; k < N; k++) begin
        m_v[k] = VI;
        m_w[k] = WI;
      end
    end else begin
      e_rd_v  = m_v[rd_addr];
      e_rd_w  = m_w[rd_addr];
      e_done  = 1'b0;
      e_spike = 1'b0;
      if (m_active) begin
        m_c++;
        if (m_c >= 1 && m_c <= N) begin
          e_core_i = cur[m_c-1];
          e_core_v = m_v[m_c-1];
          e_core_w = m_w[m_c-1];
        end
        if (m_c >= L + 2 && m_c <= N + L + 1) retire(m_c - L - 2);
        if (m_c == N + L + 1) begin
          m_active = 1'b0;
          e_done   = 1'b1;
        end
      end else if (start) begin
        m_active = 1'b1;
        m_c      = 0;
        s_edge   = edge_n;
        steps_started++;
      end
      e_busy = m_active;
    end
  end

  // Compare every output on the falling edge; also log event edges for directed checks.
  bit chk_en = 1'b0;
  int done_total = 0, spike_total = 0, busy_total = 0;
  int last_done_edge = 0, last_spike_edge = 0;
  logic [3:0] last_spike_id = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",        32'(busy),        32'(e_busy));
      check("done",        32'(done),        32'(e_done));
      check("spike_valid", 32'(spike_valid), 32'(e_spike));
      check("spike_id",    32'(spike_id),    32'(e_id));
      check("core_i",      32'(core_i),      32'(e_core_i));
      check("core_v",      32'(core_v),      32'(e_core_v));
      check("core_w",      32'(core_w),      32'(e_core_w));
      check("i_addr",      32'(i_addr),      (m_active && m_c < N) ? 32'(m_c) : 32'd0);
      check("rd_v",        32'(rd_v),        32'(e_rd_v));
      check("rd_w",        32'(rd_w),        32'(e_rd_w));
    end
    if (done === 1'b1) begin done_total++; last_done_edge = edge_n; end
    if (busy === 1'b1) busy_total++;
    if (spike_valid === 1'b1) begin
      spike_total++;
      last_spike_edge = edge_n;
      last_spike_id   = spike_id;
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the falling edge)
  // ------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_cur(input logic [15:0] val);
    for (int k = 0; k < N; k++) cur[k] = val;
  endtask

  task automatic wait_done(input string name);
    int d0, cnt;
    d0  = done_total;
    cnt = 0;
    while (done_total == d0 && cnt < 100) begin
      tick();
      cnt++;
    end
    check(name, 32'(done_total - d0), 32'd1);
  endtask

  task automatic run_step(input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(name);
  endtask

  task automatic wait_steps(input int target, input string name);
    int cnt;
    cnt = 0;
    while (steps_started < target && cnt < 100) begin
      tick();
      cnt++;
    end
    check(name, 32'(steps_started), 32'(target));
  endtask

  task automatic rb_one(input int a, input logic [15:0] ev, input logic [15:0] ew);
    rd_addr = 4'(a);
    tick();
    check("rd_v_lit", 32'(rd_v), 32'(ev));
    check("rd_w_lit", 32'(rd_w), 32'(ew));
  endtask

  task automatic rb_all(input logic [15:0] ev, input logic [15:0] ew);
    for (int a = 0; a < N; a++) rb_one(a, ev, ew);
  endtask

  // ------------------------------------------------------------------
  // Directed tests
  // ------------------------------------------------------------------
  initial begin
    int d0, b0, sp0, s1, s2, g;
    set_cur(16'h0000);
    #1 rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();

    // 1. Reset values
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_done",  32'(done),        32'd0);
    check("rst_spike", 32'(spike_valid), 32'd0);
    check("rst_corev", 32'(core_v),      32'd0);
    rst = 1'b0;
    rb_all(16'hECE1, 16'hF600);

    // 2. Normal step
    set_cur(16'h0010);
    b0 = busy_total;
    run_step("step2_done");
    check("step2_done_edge", 32'(last_done_edge - s_edge), 32'd21);
    check("step2_busy_cycles", 32'(busy_total - b0), 32'd21);
    rb_all(16'hECF1, 16'hF600);

    // 3. Spike detection on neuron 3 only
    do_reset();
    set_cur(16'h0000);
    cur[3] = 16'h3000;
    sp0 = spike_total;
    run_step("step3_done");
    check("step3_spike_count", 32'(spike_total - sp0), 32'd1);
    check("step3_spike_edge",  32'(last_spike_edge - s_edge), 32'd9);
    check("step3_spike_id",    32'(last_spike_id), 32'd3);
`ifdef NEURON_SPIKE_RESET_EN
    rb_one(3, 16'hECE1, 16'hF800);
`else
    rb_one(3, 16'h1CE1, 16'hF600);
`endif
    rb_one(2, 16'hECE1, 16'hF600);

    // 4. Second step with the same currents
    sp0 = spike_total;
    run_step("step4_done");
`ifdef NEURON_SPIKE_RESET_EN
    check("step4_spike_count", 32'(spike_total - sp0), 32'd1);
    check("step4_spike_id",    32'(last_spike_id), 32'd3);
    rb_one(3, 16'hECE1, 16'hFA00);
`else
    check("step4_spike_count", 32'(spike_total - sp0), 32'd0);
    rb_one(3, 16'h4CE1, 16'hF600);
`endif

    // 5a. start pulse while busy is ignored
    do_reset();
    set_cur(16'h0010);
    d0 = done_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("step5_done");
    check("step5_done_edge", 32'(last_done_edge - s_edge), 32'd21);
    repeat (4) tick();
    check("step5_single_done", 32'(done_total - d0), 32'd1);

    // 5b. start held high: next step samples start at S+22
    d0 = steps_started;
    start = 1'b1;
    wait_steps(d0 + 1, "held_first");
    s1 = s_edge;
    wait_steps(d0 + 2, "held_second");
    s2 = s_edge;
    start = 1'b0;
    check("held_restart_gap", 32'(s2 - s1), 32'd22);
    wait_done("held_done");

    // 6. Reset in the middle of a step
    do_reset();
    set_cur(16'h0010);
    d0  = done_total;
    sp0 = spike_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    g = 0;
    while (edge_n < s_edge + 6 && g < 50) begin
      tick();
      g++;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (25) tick();
    check("midrst_done",  32'(done_total - d0),   32'd0);
    check("midrst_spike", 32'(spike_total - sp0), 32'd0);
    rb_all(16'hECE1, 16'hF600);
    run_step("post_rst_done");
    rb_all(16'hECF1, 16'hF600);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute time limit so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
